dac_write_scheduler: RTL and testbench

Paced write queue that sits directly upstream of the serial DAC driver. It accepts DAC words from host-side logic (wire-in/pipe-in decode) at arbitrary rate and buffers them in a small FIFO. It issues them to the driver as single-cycle `wr_en` pulses spaced far enough apart that a serial frame is never interrupted. The driver has no busy output, so frame spacing is enforced entirely here.

---
 rtl/dac_write_scheduler_if.sv | 26 ++
 rtl/dac_write_scheduler.sv | 127 ++++++++++++
 tb/tb_dac_write_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_write_scheduler_if.sv
// Host-side queue controls, FIFO status and DAC driver strobe for dac_write_scheduler.
interface dac_write_scheduler_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [WIDTH-1:0]    host_data;
  logic                host_wr;
  logic                flush;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                busy;
  logic [WIDTH-1:0]    dac_din;
  logic                dac_wr_en;

  modport master (
    output host_data, host_wr, flush,
    input  full, empty, level, overflow, busy, dac_din, dac_wr_en
  );

  modport slave (
    input  host_data, host_wr, flush,
    output full, empty, level, overflow, busy, dac_din, dac_wr_en
  );
endinterface

// File: rtl/dac_write_scheduler.sv
// Paced write queue: buffers host DAC words and strobes them to the serial driver
// no more often than once every SPACING cycles, so a frame is never interrupted.
module dac_write_scheduler #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned SPACING    = 40
) (
  input logic                  clk,
  input logic                  rst,
  dac_write_scheduler_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic [CNT_W-1:0] gap;
  state_t           state;

  logic             full;
  logic             empty;
  logic             overflow;
  logic             busy;
  logic [WIDTH-1:0] dac_din;
  logic             dac_wr_en;

  logic             push_c;
  logic             pop_c;
  logic             avail_c;
  logic             gap_done_c;
  logic             drop_c;
  logic [LW-1:0]    count_next_c;
  state_t           state_next_c;

  // Flush wins over everything in its cycle: no push, no pop.
  always_comb begin
    push_c       = 1'b0;
    pop_c        = 1'b0;
    avail_c      = 1'b0;
    gap_done_c   = 1'b0;
    drop_c       = 1'b0;
    count_next_c = count;
    state_next_c = state;

    avail_c    = !empty && !bus.flush;
    gap_done_c = (gap == '0);
    push_c     = bus.host_wr && !full && !bus.flush;
    drop_c     = bus.host_wr && full && !bus.flush;
    pop_c      = avail_c && ((state == S_IDLE) || gap_done_c);

    if (bus.flush) begin
      count_next_c = '0;
    end else begin
      count_next_c = count + LW'(push_c) - LW'(pop_c);
    end

    case (state)
      S_IDLE:  if (avail_c) state_next_c = S_WAIT;
      S_WAIT:  if (gap_done_c && !avail_c) state_next_c = S_IDLE;
      default: state_next_c = S_IDLE;
    endcase
  end

  // Gap counter keeps running through a flush so spacing survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      gap       <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      dac_din   <= '0;
      dac_wr_en <= 1'b0;
    end else begin
      state     <= state_next_c;
      count     <= count_next_c;
      full      <= (count_next_c == LW'(DEPTH));
      empty     <= (count_next_c == '0);
      busy      <= (state_next_c != S_IDLE) || (count_next_c != '0);
      dac_wr_en <= pop_c;

      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_c) wptr <= wptr + AW'(1);
        if (pop_c)  rptr <= rptr + AW'(1);
      end

      if (pop_c) begin
        dac_din <= mem[rptr];
        gap     <= CNT_W'(SPACING - 1);
      end else if ((state == S_WAIT) && !gap_done_c) begin
        gap <= gap - CNT_W'(1);
      end

      if (drop_c) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wptr] <= bus.host_data;
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = count;
  assign bus.overflow  = overflow;
  assign bus.busy      = busy;
  assign bus.dac_din   = dac_din;
  assign bus.dac_wr_en = dac_wr_en;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed bench for dac_write_scheduler: latency, spacing, overflow, wrap, flush and reset.
module tb_dac_write_scheduler;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned SPACING    = 40;

  logic clk = 1'b0;
  logic rst;

  dac_write_scheduler_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  dac_write_scheduler #(
    .WIDTH(WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .SPACING(SPACING)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pc[$];
  logic [WIDTH-1:0] pd[$];

  // Pulse recorder: cycle index and data of every strobe cycle.
  always @(posedge clk) begin
    if (bus.dac_wr_en === 1'b1) begin
      pc.push_back(cyc);
      pd.push_back(bus.dac_din);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    bus.host_data = d;
    bus.host_wr   = 1'b1;
    tick(1);
    bus.host_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (bus.busy !== 1'b0 && i < 3000) begin
      tick(1);
      i++;
    end
    chk(tag, 32'(bus.busy), 0);
  endtask

  task automatic check_pulse(input string tag, input int idx, input int exp_cyc,
                             input logic [WIDTH-1:0] exp_din);
    if (idx < pc.size()) begin
      chk({tag, "_cycle"}, 32'(pc[idx]), 32'(exp_cyc));
      chk({tag, "_din"}, 32'(pd[idx]), 32'(exp_din));
    end else begin
      chk({tag, "_missing"}, 32'(pc.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_full"},      32'(bus.full), 0);
    chk({p, "_empty"},     32'(bus.empty), 1);
    chk({p, "_level"},     32'(bus.level), 0);
    chk({p, "_overflow"},  32'(bus.overflow), 0);
    chk({p, "_busy"},      32'(bus.busy), 0);
    chk({p, "_dac_din"},   32'(bus.dac_din), 0);
    chk({p, "_dac_wr_en"}, 32'(bus.dac_wr_en), 0);
  endtask

  initial begin
    int c;
    int base;
    int bad;
    int lvl_bad;

    rst           = 1'b1;
    bus.host_data = '0;
    bus.host_wr   = 1'b0;
    bus.flush     = 1'b0;
    tick(3);
    check_reset("rst");
    rst = 1'b0;
    tick(2);

    // Single word: strobe two cycles after the push cycle, then a full idle gap.
    c    = cyc;
    base = pc.size();
    push_word(16'd27);
    chk("t1_empty_after_push", 32'(bus.empty), 0);
    chk("t1_level_after_push", 32'(bus.level), 1);
    chk("t1_no_early_pulse",   32'(bus.dac_wr_en), 0);
    tick(1);
    chk("t1_wr_en", 32'(bus.dac_wr_en), 1);
    chk("t1_din",   32'(bus.dac_din), 27);
    bad = 0;
    for (int k = 1; k < int'(SPACING); k++) begin
      tick(1);
      if (bus.busy !== 1'b1 || bus.empty !== 1'b1 || bus.dac_wr_en !== 1'b0) bad++;
    end
    chk("t1_gap_busy_empty", 32'(bad), 0);
    tick(1);
    chk("t1_busy_fall", 32'(bus.busy), 0);
    tick(5);
    chk("t1_pulse_count", 32'(pc.size() - base), 1);
    check_pulse("t1_pulse", base, c + 2, 16'd27);
    chk("t1_din_hold", 32'(bus.dac_din), 27);

    // Burst of three from idle: pulses exactly SPACING apart, in order.
    c    = cyc;
    base = pc.size();
    push_word(16'd1);
    push_word(16'd2);
    push_word(16'd3);
    wait_idle("t2_idle");
    chk("t2_pulse_count", 32'(pc.size() - base), 3);
    for (int i = 0; i < 3; i++)
      check_pulse($sformatf("t2_pulse%0d", i), base + i, c + 2 + i * int'(SPACING), WIDTH'(i + 1));

    // Pointer wrap: 40 words, one per SPACING cycles.
    c    = cyc;
    base = pc.size();
    for (int i = 0; i < 40; i++) begin
      push_word(WIDTH'(i * 5 + 3));
      tick(int'(SPACING) - 1);
    end
    wait_idle("t4_idle");
    chk("t4_pulse_count", 32'(pc.size() - base), 40);
    bad = 0;
    for (int i = 0; i < 40 && base + i < pc.size(); i++)
      if (pd[base + i] !== WIDTH'(i * 5 + 3) || pc[base + i] != c + 2 + i * int'(SPACING)) bad++;
    chk("t4_order_errors", 32'(bad), 0);
    chk("t4_overflow", 32'(bus.overflow), 0);

    // Flush during WAIT, no follow-up push.
    c    = cyc;
    base = pc.size();
    for (int i = 0; i < 5; i++) push_word(WIDTH'(50 + i));
    tick(7);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    chk("t5a_level",     32'(bus.level), 0);
    chk("t5a_empty",     32'(bus.empty), 1);
    chk("t5a_din_kept",  32'(bus.dac_din), 50);
    chk("t5a_busy_gap",  32'(bus.busy), 1);
    tick(28);
    chk("t5a_busy_late", 32'(bus.busy), 1);
    tick(1);
    chk("t5a_busy_fall", 32'(bus.busy), 0);
    tick(60);
    chk("t5a_pulse_count", 32'(pc.size() - base), 1);

    // Flush with a simultaneous push, then a fresh push inside the running gap.
    c    = cyc;
    base = pc.size();
    for (int i = 0; i < 5; i++) push_word(WIDTH'(60 + i));
    tick(7);
    bus.flush     = 1'b1;
    bus.host_wr   = 1'b1;
    bus.host_data = 16'd99;
    tick(1);
    bus.flush = 1'b0;
    push_word(16'd77);
    chk("t5b_overflow", 32'(bus.overflow), 0);
    chk("t5b_level",    32'(bus.level), 1);
    wait_idle("t5b_idle");
    chk("t5b_pulse_count", 32'(pc.size() - base), 2);
    check_pulse("t5b_second", base + 1, c + 2 + int'(SPACING), 16'd77);

    // Overflow: hold scheduler in WAIT, push 17 words.
    c    = cyc;
    base = pc.size();
    push_word(16'd100);
    tick(2);
    lvl_bad = 0;
    for (int k = 1; k <= 17; k++) begin
      push_word(WIDTH'(k));
      if (bus.level !== 5'((k > 16) ? 16 : k)) lvl_bad++;
      if (k == 15) chk("t3_not_full_15", 32'(bus.full), 0);
      if (k == 16) begin
        chk("t3_full_16", 32'(bus.full), 1);
        chk("t3_no_overflow_16", 32'(bus.overflow), 0);
      end
    end
    chk("t3_level_errors", 32'(lvl_bad), 0);
    chk("t3_overflow_17",  32'(bus.overflow), 1);
    tick(23);
    chk("t3_full_after_pop",  32'(bus.full), 0);
    chk("t3_level_after_pop", 32'(bus.level), 15);
    wait_idle("t3_idle");
    chk("t3_pulse_count", 32'(pc.size() - base), 17);
    check_pulse("t3_primer", base, c + 2, 16'd100);
    bad = 0;
    for (int k = 1; k <= 16 && base + k < pc.size(); k++)
      if (pd[base + k] !== WIDTH'(k) || pc[base + k] != c + 2 + k * int'(SPACING)) bad++;
    chk("t3_drain_errors", 32'(bad), 0);
    chk("t3_overflow_sticky", 32'(bus.overflow), 1);

    // Reset five cycles after the first pulse of a three-word queue.
    c    = cyc;
    base = pc.size();
    push_word(16'd1);
    push_word(16'd2);
    push_word(16'd3);
    tick(4);
    rst = 1'b1;
    tick(1);
    check_reset("t6");
    rst = 1'b0;
    tick(200);
    chk("t6_pulse_count", 32'(pc.size() - base), 1);
    chk("t6_empty_after", 32'(bus.empty), 1);
    chk("t6_busy_after",  32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
